// File: rtl/timing_probe_pkg.sv
// Shared state encoding and default counter limits for timing_probe.
package timing_probe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t MEAS   = 2'd1;
    localparam state_t LOCKED = 2'd2;

    localparam int HW_DEF = 12;
    localparam int VW_DEF = 11;

    localparam logic [HW_DEF-1:0] HMAX = '1;
    localparam logic [VW_DEF-1:0] VMAX = '1;

endpackage

// File: rtl/timing_probe_sync_edge.sv
// Sync input register and leading-edge pulse; TIMING_PROBE_POLARITY_EN
// adds high/low phase comparison so the shorter phase is treated as active.
module sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic x_i,
    output logic edge_o,
    output logic pol_o
);

    logic raw_q;
    logic s_q;
    logic s;

`ifdef TIMING_PROBE_POLARITY_EN
    localparam int CW = 24;
    localparam logic [CW-1:0] CMAX = '1;

    logic          raw_qq;
    logic          pol_q;
    logic [CW-1:0] hi_q;
    logic [CW-1:0] lo_q;

    // On each raw rising edge the last high run and the low run just
    // ended are complete; the longer one is the inactive level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            raw_qq <= 1'b0;
            pol_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            raw_qq <= raw_q;
            if (raw_q && !raw_qq) begin
                pol_q <= (hi_q > lo_q);
                hi_q  <= {{(CW-1){1'b0}}, 1'b1};
                lo_q  <= '0;
            end else if (raw_q) begin
                if (hi_q != CMAX) hi_q <= hi_q + 1'b1;
            end else begin
                if (lo_q != CMAX) lo_q <= lo_q + 1'b1;
            end
        end
    end

    assign s     = raw_q ^ pol_q;
    assign pol_o = pol_q;
`else
    assign s     = raw_q;
    assign pol_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            raw_q <= 1'b0;
            s_q   <= 1'b0;
        end else begin
            raw_q <= x_i;
            s_q   <= s;
        end
    end

    assign edge_o = s & ~s_q;

endmodule

// File: rtl/timing_probe.sv
// Measures video timing and reports width/total/height/lock.
// Optional sync polarity auto-detect: TIMING_PROBE_POLARITY_EN.
module timing_probe
    import timing_probe_pkg::*;
#(
    parameter int HW          = HW_DEF,
    parameter int VW          = VW_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          hs_i,
    input  logic          vs_i,
    input  logic          de_i,
    output logic [HW-1:0] h_width_o,
    output logic [HW-1:0] h_total_o,
    output logic [VW-1:0] v_height_o,
    output logic [VW-1:0] v_total_o,
    output logic          locked_o,
    output logic          frame_o
);

    localparam int MW = $clog2(LOCK_FRAMES) + 1;
    localparam logic [HW-1:0] HSAT = '1;
    localparam logic [VW-1:0] VSAT = '1;

    logic          hs_e, vs_e, hs_pol, vs_pol, de_q;
    logic [HW-1:0] hcnt_q, hcnt_d, dcnt_q, dcnt_d;
    logic [VW-1:0] lines_q, lines_d, act_q, act_d;
    logic [HW-1:0] rw_q, rw_d, rt_q, rt_d;
    logic          rw_v_q, rw_v_d, rt_v_q, rt_v_d;
    logic          bad_q, bad_d;
    logic [HW-1:0] hw_q, ht_q;
    logic [VW-1:0] vh_q, vt_q;
    logic [1:0]    pol_q;
    logic          prev_ok_q, frame_q;
    logic [MW-1:0] match_q, match_d, match_n;
    state_t        state_q, state_d;
    logic          hsat, vsat, cons, same, latch;
    logic [HW-1:0] w_meas, t_meas;

    sync_edge u_hs (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .x_i    (hs_i),
        .edge_o (hs_e),
        .pol_o  (hs_pol)
    );

    sync_edge u_vs (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .x_i    (vs_i),
        .edge_o (vs_e),
        .pol_o  (vs_pol)
    );

    assign hsat   = (hcnt_q == HSAT);
    assign vsat   = (lines_q == VSAT);
    assign cons   = !(bad_q || hsat || vsat);
    assign w_meas = rw_v_q ? rw_q : '0;
    assign t_meas = rt_v_q ? rt_q : '0;
    assign same   = prev_ok_q && (w_meas == hw_q) && (t_meas == ht_q)
                 && (act_q == vh_q) && (lines_q == vt_q)
                 && ({hs_pol, vs_pol} == pol_q);

    always_comb begin
        hcnt_d  = hcnt_q;
        dcnt_d  = dcnt_q;
        lines_d = lines_q;
        act_d   = act_q;
        rw_d    = rw_q;
        rt_d    = rt_q;
        rw_v_d  = rw_v_q;
        rt_v_d  = rt_v_q;
        bad_d   = bad_q || hsat || vsat;
        if (hs_e) begin
            hcnt_d = {{(HW-1){1'b0}}, 1'b1};
            dcnt_d = {{(HW-1){1'b0}}, de_q};
        end else begin
            if (!hsat) hcnt_d = hcnt_q + 1'b1;
            if (de_q && dcnt_q != HSAT) dcnt_d = dcnt_q + 1'b1;
        end
        // A coincident HS belongs to the new frame, not the closing one.
        if (vs_e) begin
            lines_d = {{(VW-1){1'b0}}, hs_e};
            act_d   = '0;
            rw_v_d  = 1'b0;
            rt_v_d  = 1'b0;
            bad_d   = 1'b0;
        end else if (hs_e) begin
            if (!vsat) lines_d = lines_q + 1'b1;
            if (dcnt_q != '0 && act_q != VSAT) act_d = act_q + 1'b1;
            if (!rt_v_q) begin
                rt_d   = hcnt_q;
                rt_v_d = 1'b1;
            end else if (hcnt_q != rt_q) begin
                bad_d = 1'b1;
            end
            if (dcnt_q != '0) begin
                if (!rw_v_q) begin
                    rw_d   = dcnt_q;
                    rw_v_d = 1'b1;
                end else if (dcnt_q != rw_q) begin
                    bad_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        latch   = 1'b0;
        match_n = (cons && same) ? match_q + 1'b1 : '0;
        case (state_q)
            IDLE: begin
                if (vs_e) begin
                    state_d = MEAS;
                    match_d = '0;
                end
            end
            MEAS: begin
                if (vs_e) begin
                    latch   = 1'b1;
                    match_d = match_n;
                    if (cons && int'(match_n) >= LOCK_FRAMES - 1)
                        state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (vs_e) begin
                    latch = 1'b1;
                    if (!(cons && same)) begin
                        state_d = MEAS;
                        match_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (hsat) begin
            state_d = IDLE;
            match_d = '0;
            latch   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            de_q      <= 1'b0;
            hcnt_q    <= '0;
            dcnt_q    <= '0;
            lines_q   <= '0;
            act_q     <= '0;
            rw_q      <= '0;
            rt_q      <= '0;
            rw_v_q    <= 1'b0;
            rt_v_q    <= 1'b0;
            bad_q     <= 1'b0;
            hw_q      <= '0;
            ht_q      <= '0;
            vh_q      <= '0;
            vt_q      <= '0;
            pol_q     <= '0;
            prev_ok_q <= 1'b0;
            frame_q   <= 1'b0;
            match_q   <= '0;
            state_q   <= IDLE;
        end else begin
            de_q    <= de_i;
            hcnt_q  <= hcnt_d;
            dcnt_q  <= dcnt_d;
            lines_q <= lines_d;
            act_q   <= act_d;
            rw_q    <= rw_d;
            rt_q    <= rt_d;
            rw_v_q  <= rw_v_d;
            rt_v_q  <= rt_v_d;
            bad_q   <= bad_d;
            frame_q <= latch;
            match_q <= match_d;
            state_q <= state_d;
            if (latch) begin
                hw_q      <= w_meas;
                ht_q      <= t_meas;
                vh_q      <= act_q;
                vt_q      <= lines_q;
                pol_q     <= {hs_pol, vs_pol};
                prev_ok_q <= cons;
            end else if (hsat) begin
                prev_ok_q <= 1'b0;
            end
        end
    end

    assign h_width_o  = hw_q;
    assign h_total_o  = ht_q;
    assign v_height_o = vh_q;
    assign v_total_o  = vt_q;
    assign locked_o   = (state_q == LOCKED);
    assign frame_o    = frame_q;

endmodule

// File: tb/tb_timing_probe.sv
// Directed bench for timing_probe: 20x10 raster, DE 12x6.
// Polarity section is built only with TIMING_PROBE_POLARITY_EN.
module tb_timing_probe;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        hs_i, vs_i, de_i;
    logic [11:0] h_width_o, h_total_o;
    logic [10:0] v_height_o, v_total_o;
    logic        locked_o, frame_o;

    always #5 clk_i = ~clk_i;

    timing_probe #(
        .HW          (12),
        .VW          (11),
        .LOCK_FRAMES (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .hs_i       (hs_i),
        .vs_i       (vs_i),
        .de_i       (de_i),
        .h_width_o  (h_width_o),
        .h_total_o  (h_total_o),
        .v_height_o (v_height_o),
        .v_total_o  (v_total_o),
        .locked_o   (locked_o),
        .frame_o    (frame_o)
    );

    typedef struct {
        int nl; int dl; int ll; int np;
        int hw; int ht; int vh; int vt; int lk;
    } vec_t;

    vec_t tbl[16];

    int checks = 0;
    int errors = 0;
    bit inv = 1'b0;
    int npulse, pulse_pos, pos;
    int s_hw, s_ht, s_vh, s_vt, s_lk;

    task automatic chk(input string name, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    task automatic cyc(input bit h, input bit v, input bit d);
        hs_i = h ^ inv;
        vs_i = v ^ inv;
        de_i = d;
        @(posedge clk_i);
        #1;
        if (frame_o) begin
            npulse++;
            pulse_pos = pos;
            s_hw = int'(h_width_o);
            s_ht = int'(h_total_o);
            s_vh = int'(v_height_o);
            s_vt = int'(v_total_o);
            s_lk = int'(locked_o);
        end
        pos++;
    endtask

    task automatic run_line(input int total, input int dl,
                            input bit act, input bit v);
        for (int c = 0; c < total; c++)
            cyc(c < 2, v, act && c >= 4 && c < 4 + dl);
    endtask

    task automatic run_frame(input int nl, input int dl, input int ll);
        npulse = 0;
        pos = 0;
        for (int l = 0; l < nl; l++)
            run_line((l == ll) ? 21 : 20, dl, l >= 2 && l < 8, l < 2);
    endtask

    task automatic chk_pulse(input string tag, input int hw, input int ht,
                             input int vh, input int vt, input int lk);
        chk({tag, " pulses"}, npulse, 1);
        chk({tag, " latency"}, pulse_pos, 1);
        chk({tag, " h_width"}, s_hw, hw);
        chk({tag, " h_total"}, s_ht, ht);
        chk({tag, " v_height"}, s_vh, vh);
        chk({tag, " v_total"}, s_vt, vt);
        chk({tag, " locked"}, s_lk, lk);
    endtask

    initial begin
        #3ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{10, 12, -1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{10, 12, -1, 1, 12, 20, 6, 10, 0};
        tbl[2]  = '{10, 12, -1, 1, 12, 20, 6, 10, 1};
        tbl[3]  = '{10, 12, -1, 1, 12, 20, 6, 10, 1};
        tbl[4]  = '{10, 12, 5, 1, 12, 20, 6, 10, 1};
        tbl[5]  = '{10, 12, -1, 1, 12, 20, 6, 10, 0};
        tbl[6]  = '{10, 12, -1, 1, 12, 20, 6, 10, 0};
        tbl[7]  = '{10, 12, -1, 1, 12, 20, 6, 10, 1};
        tbl[8]  = '{11, 12, -1, 1, 12, 20, 6, 10, 1};
        tbl[9]  = '{10, 12, -1, 1, 12, 20, 6, 11, 0};
        tbl[10] = '{10, 12, -1, 1, 12, 20, 6, 10, 0};
        tbl[11] = '{10, 12, -1, 1, 12, 20, 6, 10, 1};
        tbl[12] = '{10, 10, -1, 1, 12, 20, 6, 10, 1};
        tbl[13] = '{10, 12, -1, 1, 10, 20, 6, 10, 0};
        tbl[14] = '{10, 12, -1, 1, 12, 20, 6, 10, 0};
        tbl[15] = '{10, 12, -1, 1, 12, 20, 6, 10, 1};

        rst_i = 1'b1;
        npulse = 0;
        pos = 0;
        repeat (3) cyc(0, 0, 0);
        chk("reset h_width", h_width_o, 0);
        chk("reset h_total", h_total_o, 0);
        chk("reset v_height", v_height_o, 0);
        chk("reset v_total", v_total_o, 0);
        chk("reset locked", locked_o, 0);
        chk("reset frame", frame_o, 0);
        rst_i = 1'b0;
        repeat (5) cyc(0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            run_frame(tbl[i].nl, tbl[i].dl, tbl[i].ll);
            if (tbl[i].np == 0)
                chk($sformatf("vec%0d pulses", i), npulse, 0);
            else
                chk_pulse($sformatf("vec%0d", i), tbl[i].hw, tbl[i].ht,
                          tbl[i].vh, tbl[i].vt, tbl[i].lk);
        end

        // Reset three lines into a frame.
        npulse = 0;
        for (int l = 0; l < 3; l++) run_line(20, 12, 1'b0, l < 2);
        rst_i = 1'b1;
        cyc(0, 0, 0);
        rst_i = 1'b0;
        chk("midrst h_width", h_width_o, 0);
        chk("midrst h_total", h_total_o, 0);
        chk("midrst v_height", v_height_o, 0);
        chk("midrst v_total", v_total_o, 0);
        chk("midrst locked", locked_o, 0);
        run_frame(10, 12, -1);
        chk("midrst first vs pulses", npulse, 0);
        run_frame(10, 12, -1);
        chk_pulse("midrst second vs", 12, 20, 6, 10, 0);
        run_frame(10, 12, -1);
        chk_pulse("midrst relock", 12, 20, 6, 10, 1);

        // Watchdog: HS held inactive past counter saturation.
        npulse = 0;
        repeat (4200) cyc(0, 0, 0);
        chk("wdog locked", locked_o, 0);
        chk("wdog pulses", npulse, 0);
        chk("wdog h_width held", h_width_o, 12);
        chk("wdog h_total held", h_total_o, 20);
        chk("wdog v_height held", v_height_o, 6);
        chk("wdog v_total held", v_total_o, 10);
        for (int l = 0; l < 3; l++) run_line(20, 12, 1'b0, 1'b0);
        run_frame(10, 12, -1);
        chk("wdog idle first vs", npulse, 0);
        run_frame(10, 12, -1);
        chk("wdog second vs pulses", npulse, 1);
        chk("wdog remeas h_total", s_ht, 20);
        chk("wdog remeas v_total", s_vt, 10);

`ifdef TIMING_PROBE_POLARITY_EN
        rst_i = 1'b1;
        cyc(0, 0, 0);
        rst_i = 1'b0;
        inv = 1'b1;
        repeat (300) cyc(0, 0, 0);
        for (int f = 0; f < 4; f++) run_frame(10, 12, -1);
        chk_pulse("pol frame4", 12, 20, 6, 10, 1);
        run_frame(10, 12, -1);
        chk_pulse("pol frame5", 12, 20, 6, 10, 1);
        inv = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
